// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
// Bundles the buses around the shared ALU arbiter:
//   req0_* / req1_*  : two requesters (valid/ready, operands, opcode)
//   alu_*            : operands/opcode to the ALU and its result/zero flag
//   rsp0_* / rsp1_*  : per-requester response handshake, shared rsp_data/rsp_zero
// Modports:
//   slave  : the arbiter side
//   master : the environment side (requesters, ALU, response consumers)
// -----------------------------------------------------------------------------
interface alu_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [OP_W-1:0]   req0_op;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [OP_W-1:0]   req1_op;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  logic              rsp0_valid;
  logic              rsp0_ready;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_zero;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  alu_result, alu_zero,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_op,
    output rsp0_valid, rsp1_valid, rsp_data, rsp_zero
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output alu_result, alu_zero,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_op,
    input  rsp0_valid, rsp1_valid, rsp_data, rsp_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational ALU between two requesters (0: EX integer path,
// 1: address/branch-compare helper) through a two-stage pipeline:
//   S1 : issue register, drives alu_a/alu_b/alu_op
//   S2 : response register, captures alu_result/alu_zero
// Round-robin on contention, full backpressure, one operation per cycle.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : alu_arbiter_if.slave (request, ALU and response buses)
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);

  // S1 (issue) state
  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_a_q, s1_a_d;
  logic [DATA_W-1:0] s1_b_q, s1_b_d;
  logic [OP_W-1:0]   s1_op_q, s1_op_d;
  logic              s1_id_q, s1_id_d;

  // S2 (response) state
  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] s2_data_q, s2_data_d;
  logic              s2_zero_q, s2_zero_d;
  logic              s2_id_q, s2_id_d;

  // Round-robin pointer: id of the most recently accepted requester
  logic              last_grant_q, last_grant_d;

  logic s2_take;
  logic s1_take;
  logic grant;
  logic accept;

  // Stage advance: a stage can take new content when empty or when its
  // current content moves on this cycle.
  assign s2_take = !s2_valid_q || (s2_id_q ? bus.rsp1_ready : bus.rsp0_ready);
  assign s1_take = !s1_valid_q || s2_take;

  // Grant never looks at ready, so there is no valid<->ready loop.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves a variable unassigned infers a latch.
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) grant = ~last_grant_q;
    else if (bus.req1_valid)              grant = 1'b1;
  end

  assign bus.req0_ready = s1_take && (grant == 1'b0);
  assign bus.req1_ready = s1_take && (grant == 1'b1);

  assign accept = (bus.req0_valid && bus.req0_ready) ||
                  (bus.req1_valid && bus.req1_ready);

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s1_op_d      = s1_op_q;
    s1_id_d      = s1_id_q;
    s2_valid_d   = s2_valid_q;
    s2_data_d    = s2_data_q;
    s2_zero_d    = s2_zero_q;
    s2_id_d      = s2_id_q;
    last_grant_d = last_grant_q;

    if (accept) begin
      s1_valid_d   = 1'b1;
      s1_a_d       = grant ? bus.req1_a  : bus.req0_a;
      s1_b_d       = grant ? bus.req1_b  : bus.req0_b;
      s1_op_d      = grant ? bus.req1_op : bus.req0_op;
      s1_id_d      = grant;
      last_grant_d = grant;
    end else if (s1_take) begin
      s1_valid_d   = 1'b0;
    end

    if (s2_take) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = bus.alu_result;
        s2_zero_d = bus.alu_zero;
        s2_id_d   = s1_id_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: data registers are reset as well, so the ALU and response buses read 0 straight out of reset.
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_op_q      <= '0;
      s1_id_q      <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_data_q    <= '0;
      s2_zero_q    <= 1'b0;
      s2_id_q      <= 1'b0;
      last_grant_q <= 1'b1;  // requester 0 wins the first contention
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      s1_valid_q   <= s1_valid_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_op_q      <= s1_op_d;
      s1_id_q      <= s1_id_d;
      s2_valid_q   <= s2_valid_d;
      s2_data_q    <= s2_data_d;
      s2_zero_q    <= s2_zero_d;
      s2_id_q      <= s2_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  // ALU sees zeros while S1 is empty.
  assign bus.alu_a  = s1_valid_q ? s1_a_q  : '0;
  assign bus.alu_b  = s1_valid_q ? s1_b_q  : '0;
  assign bus.alu_op = s1_valid_q ? s1_op_q : '0;

  assign bus.rsp0_valid = s2_valid_q && (s2_id_q == 1'b0);
  assign bus.rsp1_valid = s2_valid_q && (s2_id_q == 1'b1);
  assign bus.rsp_data   = s2_data_q;
  assign bus.rsp_zero   = s2_zero_q;

endmodule
